// File: rtl/regex_dfa_multictx.sv
// Programmable DFA regex matcher: run-time loaded char-class/transition/accept tables, NUM_CTX stream contexts.
// Latency 1 cycle byte->accept_out; char_rdy drops while cfg_we is high. Optional match counters: REGEX_MATCH_CNT_EN.
// Backpressure: config writes take priority over bytes; one byte per cycle otherwise, no same-ctx hazard.
module regex_dfa_multictx #(
    parameter int STATE_W    = 11,
    parameter int NUM_STATES = 16,
    parameter int CLASS_W    = 3,
    parameter int NUM_CTX    = 4,
    parameter int CTX_W      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [15:0]        cfg_addr,
    input  logic [15:0]        cfg_wdata,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic [CTX_W-1:0]   char_ctx,
    output logic               char_rdy,
    input  logic               ctx_ld,
    input  logic [CTX_W-1:0]   ctx_ld_id,
    input  logic [STATE_W-1:0] ctx_ld_state,
    output logic [STATE_W-1:0] state_out,
    output logic               accept_out,
    output logic [CTX_W-1:0]   accept_ctx,
    input  logic [CTX_W-1:0]   cnt_rd_ctx,
    output logic [15:0]        cnt_rd_data
);
    localparam int NUM_CLASSES = 1 << CLASS_W;
    localparam int SIDX_W      = $clog2(NUM_STATES);
    localparam logic [STATE_W-1:0] STATE_LIM = STATE_W'(NUM_STATES);

    logic [CLASS_W-1:0]    r_class [256];
    logic [STATE_W-1:0]    r_next  [NUM_STATES*NUM_CLASSES];
    logic [NUM_STATES-1:0] r_acc;
    logic [STATE_W-1:0]    r_state [NUM_CTX];
    logic                  r_accept_out;
    logic [CTX_W-1:0]      r_accept_ctx;

    logic [STATE_W-1:0] w_cfg_state;
    logic [CLASS_W-1:0] w_cfg_cls;
    logic               w_cfg_state_ok;
    logic [STATE_W-1:0] w_acc_addr;
    logic               w_acc_addr_ok;
    logic [STATE_W-1:0] w_raw;
    logic [STATE_W-1:0] w_cur;
    logic [CLASS_W-1:0] w_cls;
    logic [STATE_W-1:0] w_nxt_raw;
    logic [STATE_W-1:0] w_ns;
    logic               w_ns_acc;
    logic [STATE_W-1:0] w_ld_state;
    logic               w_ld_hit;
    logic               w_step;

    assign w_cfg_state    = cfg_addr[STATE_W+CLASS_W-1:CLASS_W];
    assign w_cfg_cls      = cfg_addr[CLASS_W-1:0];
    assign w_cfg_state_ok = (w_cfg_state < STATE_LIM);
    assign w_acc_addr     = cfg_addr[STATE_W-1:0];
    assign w_acc_addr_ok  = (w_acc_addr < STATE_LIM);

    // Any out-of-range state (stored or looked up) collapses to the start state.
    assign w_raw     = r_state[char_ctx];
    assign w_cur     = (w_raw < STATE_LIM) ? w_raw : '0;
    assign w_cls     = r_class[char_in];
    assign w_nxt_raw = r_next[{w_cur[SIDX_W-1:0], w_cls}];
    assign w_ns      = (w_nxt_raw < STATE_LIM) ? w_nxt_raw : '0;
    assign w_ns_acc  = r_acc[w_ns[SIDX_W-1:0]];

    assign w_ld_state = (ctx_ld_state < STATE_LIM) ? ctx_ld_state : '0;
    assign w_ld_hit   = ctx_ld && (ctx_ld_id == char_ctx);
    // A same-context load swallows the byte: it is accepted but never stepped.
    assign w_step     = char_in_vld && !cfg_we && !w_ld_hit;

    assign char_rdy   = !cfg_we;
    assign state_out  = w_cur;
    assign accept_out = r_accept_out;
    assign accept_ctx = r_accept_ctx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) r_class[i] <= '0;
            for (int i = 0; i < NUM_STATES*NUM_CLASSES; i++) r_next[i] <= '0;
            r_acc <= '0;
        end else if (cfg_we) begin
            if (cfg_sel == 2'd0)
                r_class[cfg_addr[7:0]] <= cfg_wdata[CLASS_W-1:0];
            else if (cfg_sel == 2'd1 && w_cfg_state_ok)
                r_next[{w_cfg_state[SIDX_W-1:0], w_cfg_cls}] <= cfg_wdata[STATE_W-1:0];
            else if (cfg_sel == 2'd2 && w_acc_addr_ok)
                r_acc[w_acc_addr[SIDX_W-1:0]] <= cfg_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CTX; c++) r_state[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CTX; c++) begin
                if (ctx_ld && ctx_ld_id == CTX_W'(c))
                    r_state[c] <= w_ld_state;
                else if (w_step && char_ctx == CTX_W'(c))
                    r_state[c] <= w_ns;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accept_out <= 1'b0;
            r_accept_ctx <= '0;
        end else if (w_step && w_ns_acc) begin
            r_accept_out <= 1'b1;
            r_accept_ctx <= char_ctx;
        end else begin
            r_accept_out <= 1'b0;
            r_accept_ctx <= '0;
        end
    end

`ifdef REGEX_MATCH_CNT_EN
    logic [15:0] r_cnt [NUM_CTX];

    // Counts accept_out pulses; a load on the context clears it and wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CTX; c++) r_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CTX; c++) begin
                if (ctx_ld && ctx_ld_id == CTX_W'(c))
                    r_cnt[c] <= '0;
                else if (r_accept_out && r_accept_ctx == CTX_W'(c) && r_cnt[c] != 16'hFFFF)
                    r_cnt[c] <= r_cnt[c] + 16'd1;
            end
        end
    end

    assign cnt_rd_data = r_cnt[cnt_rd_ctx];

    logic w_unused;
    assign w_unused = ^{cfg_addr[15:STATE_W+CLASS_W], cfg_wdata[15:STATE_W]};
`else
    assign cnt_rd_data = 16'h0000;

    logic w_unused;
    assign w_unused = ^{cfg_addr[15:STATE_W+CLASS_W], cfg_wdata[15:STATE_W], cnt_rd_ctx};
`endif

endmodule

// File: tb/tb_regex_dfa_multictx.sv
// Randomized + directed bench for regex_dfa_multictx; reference model of the tables/contexts, scoreboard on accept_out.
module tb_regex_dfa_multictx;
    localparam int NUM_STATES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [7:0]  char_in = '0;
    logic        char_in_vld = 1'b0;
    logic [1:0]  char_ctx = '0;
    logic        char_rdy;
    logic        ctx_ld = 1'b0;
    logic [1:0]  ctx_ld_id = '0;
    logic [10:0] ctx_ld_state = '0;
    logic [10:0] state_out;
    logic        accept_out;
    logic [1:0]  accept_ctx;
    logic [1:0]  cnt_rd_ctx = '0;
    logic [15:0] cnt_rd_data;

    regex_dfa_multictx dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .char_in(char_in), .char_in_vld(char_in_vld), .char_ctx(char_ctx), .char_rdy(char_rdy),
        .ctx_ld(ctx_ld), .ctx_ld_id(ctx_ld_id), .ctx_ld_state(ctx_ld_state),
        .state_out(state_out), .accept_out(accept_out), .accept_ctx(accept_ctx),
        .cnt_rd_ctx(cnt_rd_ctx), .cnt_rd_data(cnt_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(string name, longint got, longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference model
    int m_class [256];
    int m_next  [NUM_STATES][8];
    bit m_acc   [NUM_STATES];
    int m_state [4];
    int m_cnt   [4];
    bit pend_vld;
    int pend_ctx;

    typedef struct { int cyc; int ctx; } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        foreach (m_class[i]) m_class[i] = 0;
        foreach (m_next[i, j]) m_next[i][j] = 0;
        foreach (m_acc[i]) m_acc[i] = 1'b0;
        foreach (m_state[i]) m_state[i] = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        pend_vld = 1'b0;
        pend_ctx = 0;
        sb.delete();
    endtask

    // One clock of stimulus: check combinational outputs, advance the model, let the edge happen.
    task automatic tick();
        int ns;
        int st;
        bit step;
        bit acc;
        @(negedge clk);
        chk("char_rdy", char_rdy, !cfg_we);
        chk("state_out", state_out, m_state[char_ctx]);
`ifdef REGEX_MATCH_CNT_EN
        chk("cnt_rd_data", cnt_rd_data, m_cnt[cnt_rd_ctx]);
`else
        chk("cnt_rd_data", cnt_rd_data, 0);
`endif
        ns = 0;
        acc = 1'b0;
        step = char_in_vld && !cfg_we && !(ctx_ld && ctx_ld_id == char_ctx);
        if (step) begin
            ns = m_next[m_state[char_ctx]][m_class[char_in]];
            if (ns >= NUM_STATES) ns = 0;
            m_state[char_ctx] = ns;
            acc = m_acc[ns];
            if (acc) sb.push_back('{cyc + 1, int'(char_ctx)});
        end
        if (pend_vld && !(ctx_ld && int'(ctx_ld_id) == pend_ctx) && m_cnt[pend_ctx] < 65535)
            m_cnt[pend_ctx]++;
        if (ctx_ld) m_cnt[ctx_ld_id] = 0;
        pend_vld = acc;
        pend_ctx = int'(char_ctx);
        if (cfg_we) begin
            if (cfg_sel == 2'd0) m_class[cfg_addr[7:0]] = int'(cfg_wdata[2:0]);
            else if (cfg_sel == 2'd1) begin
                st = int'(cfg_addr[13:3]);
                if (st < NUM_STATES) m_next[st][cfg_addr[2:0]] = int'(cfg_wdata[10:0]);
            end else if (cfg_sel == 2'd2) begin
                st = int'(cfg_addr[10:0]);
                if (st < NUM_STATES) m_acc[st] = cfg_wdata[0];
            end
        end
        if (ctx_ld) m_state[ctx_ld_id] = (int'(ctx_ld_state) < NUM_STATES) ? int'(ctx_ld_state) : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(int sel, int addr, int data);
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_addr = 16'(addr); cfg_wdata = 16'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(int c, byte ch);
        char_in_vld = 1'b1; char_ctx = 2'(c); char_in = ch;
        tick();
        char_in_vld = 1'b0;
    endtask

    task automatic feed(int c, string s);
        for (int i = 0; i < s.len(); i++) send(c, s[i]);
    endtask

    task automatic look(int c);
        char_ctx = 2'(c); cnt_rd_ctx = 2'(c);
        tick();
    endtask

    // Scoreboard monitor: every negedge either an expected pulse is due or accept_out must be low.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("no_x", $isunknown({accept_out, accept_ctx, state_out, char_rdy, cnt_rd_data}), 0);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk("accept_out", accept_out, 1);
                chk("accept_ctx", accept_ctx, sb[0].ctx);
                void'(sb.pop_front());
            end else if (accept_out !== 1'b0) begin
                chk("accept_out", accept_out, 0);
            end
        end
    end

    string alpha = "MDT 0123456789xz";

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_accept_out", accept_out, 0);
        chk("rst_accept_ctx", accept_ctx, 0);
        chk("rst_state_out", state_out, 0);
        chk("rst_cnt", cnt_rd_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // "MDTM +[0-9]": classes M=1 D=2 T=3 space=4 digit=5; states 0..6, 6 accepting.
        cfg(0, "M", 1); cfg(0, "D", 2); cfg(0, "T", 3); cfg(0, " ", 4);
        for (int d = 0; d < 10; d++) cfg(0, "0" + d, 5);
        for (int s = 0; s < 7; s++) cfg(1, (s << 3) | 1, 1);
        cfg(1, (1 << 3) | 2, 2);
        cfg(1, (2 << 3) | 3, 3);
        cfg(1, (3 << 3) | 1, 4);
        cfg(1, (4 << 3) | 4, 5);
        cfg(1, (5 << 3) | 4, 5);
        cfg(1, (5 << 3) | 5, 6);
        cfg(2, 6, 1);

        feed(0, "MDTM 5");
        look(0);
        feed(0, "MDTM  9");
        look(0);

        send(1, "M"); send(2, "M"); send(1, "D"); send(2, "D");
        send(2, "T"); send(2, "M"); send(2, " "); send(2, "7");
        send(1, "T"); send(1, "M"); send(1, " "); send(1, "3");
        look(1); look(2);

        // Config holds off a pending byte, then it steps.
        char_in_vld = 1'b1; char_ctx = 2'd0; char_in = "M";
        cfg_we = 1'b1; cfg_sel = 2'd3; cfg_addr = 16'd6; cfg_wdata = 16'h0;
        repeat (3) tick();
        cfg_we = 1'b0;
        tick();
        char_in_vld = 1'b0;
        look(0);

        // Same-context load swallows the final byte; other-context load does not.
        feed(0, "MDTM ");
        ctx_ld = 1'b1; ctx_ld_id = 2'd0; ctx_ld_state = 11'd0;
        send(0, "5");
        ctx_ld = 1'b0;
        look(0);
        feed(0, "MDTM ");
        ctx_ld = 1'b1; ctx_ld_id = 2'd3; ctx_ld_state = 11'd20;
        send(0, "5");
        ctx_ld = 1'b0;
        look(3);
        ctx_ld = 1'b1; ctx_ld_id = 2'd3; ctx_ld_state = 11'd5;
        tick();
        ctx_ld = 1'b0;
        look(3);
        send(3, "9");

        // Out-of-range next state returns to start; out-of-range table writes are dropped.
        cfg(0, "x", 6);
        cfg(1, 6, 20);
        feed(1, "MDx");
        look(1);
        cfg(2, 22, 0);
        cfg(1, (17 << 3) | 2, 0);
        feed(2, "MDTM 1");
        look(2);

        // Random interleaved traffic with loads and harmless config writes.
        for (int n = 0; n < 1500; n++) begin
            char_in_vld  = ($urandom_range(0, 3) != 0);
            char_ctx     = 2'($urandom_range(0, 3));
            char_in      = alpha[$urandom_range(0, 15)];
            ctx_ld       = ($urandom_range(0, 15) == 0);
            ctx_ld_id    = 2'($urandom_range(0, 3));
            ctx_ld_state = 11'($urandom_range(0, 20));
            cfg_we       = ($urandom_range(0, 19) == 0);
            cfg_sel      = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
            cfg_addr     = 16'h007a;
            cfg_wdata    = 16'($urandom);
            cnt_rd_ctx   = 2'($urandom_range(0, 3));
            tick();
        end
        char_in_vld = 1'b0; ctx_ld = 1'b0; cfg_we = 1'b0;
        repeat (2) tick();

        // Asynchronous reset right after a matching byte clears the pulse at once.
        feed(0, "MDTM 5");
        char_ctx = 2'd0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_accept_out", accept_out, 0);
        chk("arst_accept_ctx", accept_ctx, 0);
        chk("arst_state_out", state_out, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        feed(0, "MDTM 5");
        look(0);
        repeat (2) tick();

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
